// File: rtl/syn_pkg.sv
// Shared constants and state encoding for the sync-line master/slave pair.
package syn_pkg;

  localparam int unsigned BIT_US_DEF  = 10;
  localparam int unsigned LOST_US_DEF = 1100000;
  localparam int unsigned FRAME_BITS  = 11;
  localparam int unsigned DATA_BITS   = FRAME_BITS - 3;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } syn_state_e;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/syn_s_sync2.sv
// Two-flop synchronizer for the asynchronous sync line; resets to idle-high.
module syn_s_sync2 (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/syn_s_rx.sv
// Sync-frame receiver: decodes start/8 data/even parity/stop frames into a local sync pulse,
// sequence number and error/loss indications.
module syn_s_rx
  import syn_pkg::*;
#(
  parameter int unsigned BIT_US  = BIT_US_DEF,
  parameter int unsigned LOST_US = LOST_US_DEF
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pluse_us,
  input  logic       rx_syn,
  output logic       syn_pluse,
  output logic [7:0] syn_seq,
  output logic       err_parity,
  output logic       err_frame,
  output logic       seq_gap,
  output logic       syn_lost
);

  localparam int unsigned TW = (BIT_US > 1) ? $clog2(BIT_US) : 1;
  localparam int unsigned LW = $clog2(LOST_US + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(BIT_US / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_US - 1);

  logic          w_rx;
  logic          w_fall;
  logic          w_sample;
  logic          w_lost_rise;
  logic          r_prev;
  logic [1:0]    r_warm;
  syn_state_e    r_state;
  logic [TW-1:0] r_tick;
  logic [3:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par_err;
  logic          r_first;
  logic          r_syn_pluse;
  logic [7:0]    r_syn_seq;
  logic          r_err_parity;
  logic          r_err_frame;
  logic          r_seq_gap;
  logic [LW-1:0] r_lost_cnt;

  syn_s_sync2 u_sync (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .i_d     (rx_syn),
    .o_q     (w_rx)
  );

  // The synchronizer's reset value is not line data; only trust edges once the
  // pipeline and r_prev hold real samples, so a line held low across reset is no start.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
      r_warm <= 2'd0;
    end else begin
      r_prev <= w_rx;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  assign w_fall   = (r_warm == 2'd3) && r_prev && !w_rx;
  assign w_sample = pluse_us &&
                    (r_tick == ((r_state == StStart) ? TICK_HALF : TICK_LAST));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_tick       <= '0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_first      <= 1'b1;
      r_syn_pluse  <= 1'b0;
      r_syn_seq    <= '0;
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
      r_seq_gap    <= 1'b0;
    end else begin
      r_syn_pluse  <= 1'b0;
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
      r_seq_gap    <= 1'b0;
      if (w_lost_rise) r_first <= 1'b1;
      if (r_state != StIdle && pluse_us) r_tick <= w_sample ? '0 : r_tick + TW'(1);
      unique case (r_state)
        StIdle: begin
          if (w_fall) begin
            r_state <= StStart;
            r_tick  <= '0;
          end
        end
        StStart: begin
          if (w_sample) begin
            if (w_rx) begin
              r_err_frame <= 1'b1;
              r_state     <= StIdle;
            end else begin
              r_bitcnt <= '0;
              r_state  <= StData;
            end
          end
        end
        StData: begin
          if (w_sample) begin
            r_shift  <= {w_rx, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'(DATA_BITS - 1)) r_state <= StParity;
          end
        end
        StParity: begin
          if (w_sample) begin
            r_par_err <= (w_rx != even_parity(r_shift));
            r_state   <= StStop;
          end
        end
        StStop: begin
          if (w_sample) begin
            r_state <= StIdle;
            if (!w_rx) begin
              r_err_frame <= 1'b1;
            end else if (r_par_err) begin
              r_err_parity <= 1'b1;
            end else begin
              r_syn_pluse <= 1'b1;
              r_syn_seq   <= r_shift;
              r_seq_gap   <= !r_first && (r_shift != r_syn_seq + 8'd1);
              r_first     <= 1'b0;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Cleared by the registered pulse, so syn_lost drops the cycle after syn_pluse.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_lost_cnt <= '0;
    end else if (r_syn_pluse) begin
      r_lost_cnt <= '0;
    end else if (pluse_us && !syn_lost) begin
      r_lost_cnt <= r_lost_cnt + LW'(1);
    end
  end

  assign syn_lost    = (r_lost_cnt == LW'(LOST_US));
  assign w_lost_rise = pluse_us && !r_syn_pluse && (r_lost_cnt == LW'(LOST_US - 1));

  assign syn_pluse  = r_syn_pluse;
  assign syn_seq    = r_syn_seq;
  assign err_parity = r_err_parity;
  assign err_frame  = r_err_frame;
  assign seq_gap    = r_seq_gap;

endmodule
